// File: rtl/serial_tx_arbiter.sv
// -----------------------------------------------------------------------------
// serial_tx_arbiter
//
// Shares a narrow serial transmit link between two requesters
// (0 = instruction fetch, 1 = data access). Each accepted request becomes
// one message: a single header cycle followed by the payload shifted out
// LSB-first, IO_BITS bits per cycle. Ties are resolved round-robin.
//
// Parameters:
//   IO_BITS   - link width (>= 2)
//   DATA_BITS - payload width (multiple of IO_BITS)
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [1:0] request pending per requester
//   req_data0  in   payload of requester 0
//   req_data1  in   payload of requester 1
//   req_jump0  in   requester 0 jump flag, carried in the header
//   req_ready  out  [1:0] one-hot grant, combinational from req_valid/state
//   tx_pins    out  serial link data (registered)
//   tx_fetch   out  requester-0 header marker (registered)
//   tx_jump    out  requester-0 header with jump flag (registered)
//   busy       out  header or payload on the link (registered)
// -----------------------------------------------------------------------------
module serial_tx_arbiter #(
    parameter int IO_BITS   = 2,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    input  logic [DATA_BITS-1:0] req_data0,
    input  logic [DATA_BITS-1:0] req_data1,
    input  logic                 req_jump0,
    output logic [1:0]           req_ready,
    output logic [IO_BITS-1:0]   tx_pins,
    output logic                 tx_fetch,
    output logic                 tx_jump,
    output logic                 busy
);

    localparam int N      = DATA_BITS / IO_BITS;
    localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;

    // state_reg describes what is on the link during the current cycle.
    logic [1:0]           state_reg,      state_next;
    logic [BEAT_W-1:0]    beat_reg,       beat_next;
    logic [DATA_BITS-1:0] shift_reg,      shift_next;
    logic                 last_grant_reg, last_grant_next;
    logic [IO_BITS-1:0]   tx_pins_reg,    tx_pins_next;
    logic                 tx_fetch_reg,   tx_fetch_next;
    logic                 tx_jump_reg,    tx_jump_next;
    logic                 busy_reg,       busy_next;

    logic                 accept_slot;
    logic                 grant0;
    logic                 grant1;
    logic                 accept;
    logic                 grant_id;
    logic [DATA_BITS-1:0] payload_sel;
    logic [IO_BITS-1:0]   header_bits;

    // The last payload beat doubles as an accept slot so messages can run
    // back-to-back without an idle cycle in between.
    assign accept_slot = (state_reg == ST_IDLE) ||
                         ((state_reg == ST_PAY) && (beat_reg == LAST_BEAT));

    // last_grant_reg = 1 means requester 1 was granted most recently, so
    // requester 0 wins the next tie.
    assign grant0 = req_valid[0] & (~req_valid[1] |  last_grant_reg);
    assign grant1 = req_valid[1] & (~req_valid[0] | ~last_grant_reg);

    // Gated with rst_n so the grant reads 0 while reset is held, even though
    // the state register already sits in IDLE.
    assign req_ready = (accept_slot && rst_n) ? {grant1, grant0} : 2'b00;

    assign accept      = |req_ready;
    assign grant_id    = req_ready[1];
    assign payload_sel = grant_id ? req_data1 : req_data0;

    // Header: start marker in the MSB, requester id in the LSB, zeros between.
    for (genvar gi = 0; gi < IO_BITS; gi++) begin : g_hdr
        if (gi == IO_BITS - 1) begin : g_mark
            assign header_bits[gi] = 1'b1;
        end else if (gi == 0) begin : g_id
            assign header_bits[gi] = grant_id;
        end else begin : g_zero
            assign header_bits[gi] = 1'b0;
        end
    end

    always_comb begin
        state_next      = state_reg;
        beat_next       = beat_reg;
        shift_next      = shift_reg;
        last_grant_next = last_grant_reg;
        tx_pins_next    = '0;
        tx_fetch_next   = 1'b0;
        tx_jump_next    = 1'b0;
        busy_next       = 1'b0;

        if (accept) begin
            state_next      = ST_HDR;
            beat_next       = '0;
            shift_next      = payload_sel;
            last_grant_next = grant_id;
            tx_pins_next    = header_bits;
            tx_fetch_next   = ~grant_id;
            // The jump flag only belongs to fetch messages.
            tx_jump_next    = ~grant_id & req_jump0;
            busy_next       = 1'b1;
        end else begin
            case (state_reg)
                ST_HDR: begin
                    // Present payload beat 0 next cycle.
                    state_next   = ST_PAY;
                    beat_next    = '0;
                    tx_pins_next = shift_reg[IO_BITS-1:0];
                    shift_next   = shift_reg >> IO_BITS;
                    busy_next    = 1'b1;
                end
                ST_PAY: begin
                    if (beat_reg != LAST_BEAT) begin
                        beat_next    = beat_reg + 1'b1;
                        tx_pins_next = shift_reg[IO_BITS-1:0];
                        shift_next   = shift_reg >> IO_BITS;
                        busy_next    = 1'b1;
                    end else begin
                        // Last beat with no new request: link goes quiet.
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            beat_reg       <= '0;
            shift_reg      <= '0;
            last_grant_reg <= 1'b1;
            tx_pins_reg    <= '0;
            tx_fetch_reg   <= 1'b0;
            tx_jump_reg    <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            beat_reg       <= beat_next;
            shift_reg      <= shift_next;
            last_grant_reg <= last_grant_next;
            tx_pins_reg    <= tx_pins_next;
            tx_fetch_reg   <= tx_fetch_next;
            tx_jump_reg    <= tx_jump_next;
            busy_reg       <= busy_next;
        end
    end

    assign tx_pins  = tx_pins_reg;
    assign tx_fetch = tx_fetch_reg;
    assign tx_jump  = tx_jump_reg;
    assign busy     = busy_reg;

endmodule

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Shares the CPU's narrow serial transmit link between two requesters: requester 0 is instruction fetch, requester 1 is data access. Each accepted request becomes one message on `tx_pins`: a one-cycle header, then the payload word shifted out LSB-first, `IO_BITS` bits per cycle. Arbitration is round-robin. All link outputs are registered, so the block drives the top-level output register path directly.

## Interface
- `IO_BITS`, 2: width of the serial link. Must be at least 2.
- `DATA_BITS`, 16: payload width. Must be a multiple of `IO_BITS`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req_valid`  in  2: bit i high means requester i has a message pending.
- `req_data0`  in  DATA_BITS: payload of requester 0.
- `req_data1`  in  DATA_BITS: payload of requester 1.
- `req_jump0`  in  1: requester 0 flag, carried in the header.
- `req_ready`  out  2: one-hot grant. Bit i high means requester i is accepted on this edge (combinational).
- `tx_pins`  out  IO_BITS: serial link data (registered).
- `tx_fetch`  out  1: high during a requester-0 header (registered).
- `tx_jump`  out  1: high during a requester-0 header whose captured `req_jump0` was 1 (registered).
- `busy`  out  1: high while a header or payload cycle is on the link (registered).

## Operation
- States:
  - IDLE.
  - HDR: one cycle.
  - PAY: `N = DATA_BITS/IO_BITS` cycles, tracked by a beat counter 0..N-1.
- Accept slot: any cycle in IDLE, or the PAY cycle with beat = N-1.
  - In an accept slot, with any `req_valid` bit set, the arbiter asserts exactly one `req_ready` bit.
  - Outside accept slots, `req_ready` = 0, regardless of `req_valid`.
- Arbitration:
  - Only one requester valid: grant it.
  - Both valid: grant the requester that was not granted last. The last-grant register updates on every accept.
- On the accept edge the block captures:
  - the payload into the shift register;
  - the requester id;
  - `req_jump0`, masked to 0 when the id is 1.
  - Next state is HDR.
- HDR cycle outputs:
  - `tx_pins[IO_BITS-1]` = 1 (start marker).
  - `tx_pins[0]` = requester id; any other bits = 0.
  - `tx_fetch` = (id == 0); `tx_jump` = captured jump.
  - `busy` = 1.
- PAY beat k outputs:
  - `tx_pins` = payload bits [k*IO_BITS +: IO_BITS].
  - `tx_fetch` = 0, `tx_jump` = 0, `busy` = 1.
  - The shift register moves right by `IO_BITS` each beat.
- At the end of the last beat:
  - If a grant occurred, next state is HDR. Messages run back-to-back with no idle gap.
  - Otherwise next state is IDLE, with `tx_pins` = 0 and `busy` = 0.
- Requesters must hold `req_valid` and data stable until `req_ready` is seen. Dropping `req_valid` before the grant withdraws the request with no side effect.
- The beat counter wraps N-1 -> 0 only through a new accept. There is no modulo behaviour beyond that.

## Timing
- Reset values: `tx_pins` = 0, `tx_fetch` = 0, `tx_jump` = 0, `busy` = 0, `req_ready` = 0. State is IDLE and last-grant = 1, so requester 0 wins the first tie.
- Reset asserted mid-message: all outputs clear immediately (asynchronous). The partial message is abandoned and is not resumed after reset.
- Latency: accept at edge t puts the header on the link in cycle t+1 and payload in cycles t+2 .. t+1+N.
- Throughput: one message per N+1 cycles under continuous load (9 cycles with the defaults).
- The next accept slot is cycle t+1+N, so the next header appears in cycle t+2+N.
- `req_ready` depends combinationally on `req_valid` and state only. There is no combinational path from `req_data*` to any output.

## Test plan
- Reset then idle: `rst_n` = 0 then 1, `req_valid` = 0 for 20 cycles -> `tx_pins` = 0, `busy` = 0, `req_ready` = 0 throughout.
- Single fetch: `req_valid` = 01, `req_data0` = 16'hA5C3, `req_jump0` = 1 -> `req_ready` = 01 for one cycle.
  - Header: `tx_pins` = 2'b10, `tx_fetch` = 1, `tx_jump` = 1.
  - Payload `tx_pins` sequence 3,0,0,3,1,1,2,2, then idle.
- Data message: `req_valid` = 10, `req_data1` = 16'h0001, `req_jump0` = 1 -> header `tx_pins` = 2'b11, `tx_fetch` = 0, `tx_jump` = 0. Payload 1,0,0,0,0,0,0,0.
- Contention: both valid and held from reset for 4 messages -> grant order 0,1,0,1. Headers spaced exactly 9 cycles apart, `busy` continuously 1.
- Back-to-back with late arrival: requester 1 raises `req_valid` during beat 3 of a requester-0 message -> its `req_ready` pulses at beat 7. Its header follows with no idle cycle.
- Async reset at payload beat 4 -> outputs are 0 within the same cycle. After release with `req_valid` = 11, requester 0 is granted first.
